// File: rtl/switch_scan_controller.sv
// rtl/switch_scan_controller.sv - serial popcount of a captured switch vector with start/busy/done handshake
// Optional macro SWITCH_SCAN_EARLY_EXIT_EN ends the scan once no set bits remain.
module switch_scan_controller #(
  parameter int N_SW = 15,
  parameter int CW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N_SW-1:0] sw,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   count,
  output logic            all_on
);

  localparam int IW = (N_SW > 1) ? $clog2(N_SW) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_SW - 1);
  localparam logic [CW-1:0] FULL     = CW'(N_SW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [N_SW-1:0] shreg;
  logic [CW-1:0]   acc;
  logic [IW-1:0]   idx;

  logic [CW-1:0]   acc_next;
  logic            last;

  assign acc_next = acc + CW'(shreg[0]);

`ifdef SWITCH_SCAN_EARLY_EXIT_EN
  // Nothing left above the bit being consumed means the total is already final.
  assign last = (idx == IDX_LAST) || ((shreg >> 1) == '0);
`else
  assign last = (idx == IDX_LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      acc    <= '0;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
      all_on <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg <= sw;
            acc   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          acc   <= acc_next;
          shreg <= shreg >> 1;
          idx   <= idx + IW'(1);
          if (last) begin
            count  <= acc_next;
            all_on <= (acc_next == FULL);
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          // Unconditional return; a start seen here is dropped, not queued.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_scan_controller.sv
// tb/tb_switch_scan_controller.sv - directed self-checking bench for switch_scan_controller
module tb_switch_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [14:0] sw;
  logic        busy;
  logic        done;
  logic [3:0]  count;
  logic        all_on;

  int total = 0;
  int bad   = 0;

`ifdef SWITCH_SCAN_EARLY_EXIT_EN
  localparam int L_000F = 5;
  localparam int L_0101 = 10;
  localparam int L_0003 = 3;
  localparam int L_0000 = 2;
`else
  localparam int L_000F = 16;
  localparam int L_0101 = 16;
  localparam int L_0003 = 16;
  localparam int L_0000 = 16;
`endif
  localparam int L_FULL = 16;

  always #5 clk = ~clk;

  switch_scan_controller #(.N_SW(15), .CW(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sw     (sw),
    .busy   (busy),
    .done   (done),
    .count  (count),
    .all_on (all_on)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start pulse in cycle 0, observe cycles 1..ncyc; leaves the bench just after an edge.
  task automatic run_plain(input logic [14:0] v, input int ncyc, output int first, output int nd,
                           output int nb, output logic [3:0] c, output logic a);
    sw = v;
    start = 1'b1;
    first = -1;
    nd = 0;
    nb = 0;
    c = 'x;
    a = 1'bx;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      start = 1'b0;
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        nd++;
        if (first < 0) begin
          first = k;
          c = count;
          a = all_on;
        end
      end
    end
    tick();
  endtask

  task automatic test_reset;
    int nd;
    int nb;
    rst = 1'b1;
    start = 1'b0;
    sw = '0;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (all_on !== 1'b0) begin bad++; $display("FAIL reset_all_on: got %b want 0", all_on); end
    nd = 0;
    nb = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    total++; if (nd != 0) begin bad++; $display("FAIL reset_idle_done: got %0d pulses want 0", nd); end
    total++; if (nb != 0) begin bad++; $display("FAIL reset_idle_busy: got %0d cycles want 0", nb); end
    tick();
  endtask

  task automatic test_full_count;
    int first, nd, nb;
    logic [3:0] c;
    logic a;
    run_plain(15'h7FFF, 20, first, nd, nb, c, a);
    total++; if (first != L_FULL) begin bad++; $display("FAIL full_done_cycle: got %0d want %0d", first, L_FULL); end
    total++; if (nd != 1) begin bad++; $display("FAIL full_done_pulses: got %0d want 1", nd); end
    total++; if (nb != 16) begin bad++; $display("FAIL full_busy_cycles: got %0d want 16", nb); end
    total++; if (c !== 4'd15) begin bad++; $display("FAIL full_count: got %0d want 15", c); end
    total++; if (a !== 1'b1) begin bad++; $display("FAIL full_all_on: got %b want 1", a); end
    run_plain(15'h5555, 20, first, nd, nb, c, a);
    total++; if (first != L_FULL) begin bad++; $display("FAIL alt_done_cycle: got %0d want %0d", first, L_FULL); end
    total++; if (c !== 4'd8) begin bad++; $display("FAIL alt_count: got %0d want 8", c); end
    total++; if (a !== 1'b0) begin bad++; $display("FAIL alt_all_on: got %b want 0", a); end
    total++; if (count !== 4'd8) begin bad++; $display("FAIL alt_count_hold: got %0d want 8", count); end
  endtask

  task automatic test_ignored_start;
    int first = -1;
    int nd = 0;
    logic [3:0] c = 'x;
    logic a = 1'bx;
    sw = 15'h000F;
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      start = (k == 5);
      sw = (k == 5) ? 15'h7FFF : 15'h000F;
      @(negedge clk);
      if (done) begin
        nd++;
        if (first < 0) begin
          first = k;
          c = count;
          a = all_on;
        end
      end
    end
    start = 1'b0;
    total++; if (first != L_000F) begin bad++; $display("FAIL ign_done_cycle: got %0d want %0d", first, L_000F); end
    total++; if (nd != 1) begin bad++; $display("FAIL ign_done_pulses: got %0d want 1", nd); end
    total++; if (c !== 4'd4) begin bad++; $display("FAIL ign_count: got %0d want 4", c); end
    total++; if (a !== 1'b0) begin bad++; $display("FAIL ign_all_on: got %b want 0", a); end
    tick();
  endtask

  task automatic test_reset_mid_scan;
    int nd = 0;
    int nb_after = 0;
    int first, nd2, nb;
    logic [3:0] c;
    logic a;
    sw = 15'h7FFF;
    start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      start = 1'b0;
      rst = (k == 7);
      @(negedge clk);
      if (done) nd++;
      if (k >= 8 && busy) nb_after++;
    end
    rst = 1'b0;
    total++; if (nb_after != 0) begin bad++; $display("FAIL rst_mid_busy: got %0d busy cycles want 0", nb_after); end
    total++; if (nd != 0) begin bad++; $display("FAIL rst_mid_done: got %0d pulses want 0", nd); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_mid_count: got %0d want 0", count); end
    tick();
    run_plain(15'h0101, 20, first, nd2, nb, c, a);
    total++; if (first != L_0101) begin bad++; $display("FAIL rst_fresh_cycle: got %0d want %0d", first, L_0101); end
    total++; if (c !== 4'd2) begin bad++; $display("FAIL rst_fresh_count: got %0d want 2", c); end
  endtask

  task automatic test_data_ignored;
    int first = -1;
    logic [3:0] c = 'x;
    sw = 15'h0003;
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      start = 1'b0;
      sw = ~sw;
      @(negedge clk);
      if (done && first < 0) begin
        first = k;
        c = count;
      end
    end
    total++; if (first != L_0003) begin bad++; $display("FAIL hold_done_cycle: got %0d want %0d", first, L_0003); end
    total++; if (c !== 4'd2) begin bad++; $display("FAIL hold_count: got %0d want 2", c); end
    tick();
  endtask

  task automatic test_back_to_back;
    int dc[$];
    sw = 15'h7FFF;
    start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      @(negedge clk);
      if (done) dc.push_back(k);
    end
    start = 1'b0;
    total++; if (dc.size() != 3) begin bad++; $display("FAIL b2b_pulses: got %0d want 3", dc.size()); end
    if (dc.size() >= 3) begin
      total++; if (dc[0] != 16) begin bad++; $display("FAIL b2b_first: got %0d want 16", dc[0]); end
      total++; if (dc[1] != 33) begin bad++; $display("FAIL b2b_second: got %0d want 33", dc[1]); end
      total++; if (dc[2] != 50) begin bad++; $display("FAIL b2b_third: got %0d want 50", dc[2]); end
    end
    for (int k = 0; k < 25; k++) tick();
  endtask

  task automatic test_early_exit;
    logic [14:0] vec [3] = '{15'h0000, 15'h0003, 15'h4000};
    int          lat [3] = '{L_0000, L_0003, L_FULL};
    logic [3:0]  exp [3] = '{4'd0, 4'd2, 4'd1};
    int first, nd, nb;
    logic [3:0] c;
    logic a;
    for (int i = 0; i < 3; i++) begin
      run_plain(vec[i], 20, first, nd, nb, c, a);
      total++; if (first != lat[i]) begin bad++; $display("FAIL early_cycle_%0h: got %0d want %0d", vec[i], first, lat[i]); end
      total++; if (c !== exp[i]) begin bad++; $display("FAIL early_count_%0h: got %0d want %0d", vec[i], c, exp[i]); end
      total++; if (nd != 1) begin bad++; $display("FAIL early_pulses_%0h: got %0d want 1", vec[i], nd); end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sw = '0;
    test_reset();
    test_full_count();
    test_ignored_start();
    test_reset_mid_scan();
    test_data_ignored();
    test_back_to_back();
    test_early_exit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_scan_controller.md
# switch_scan_controller

Sequential controller for the 15-switch count datapath. On a start request it captures a 15-bit switch vector and scans it one switch per clock, accumulating the number of closed switches into a 4-bit result. A start/busy/done handshake lets one shared counting resource be sequenced from higher-level control logic instead of a wide combinational adder tree.

## Interface
- `N_SW`, default 15: number of switch inputs scanned.
- `CW`, default 4: count width. Must satisfy 2^CW > N_SW.
- `clk` in, 1 bit: single clock; all state changes on the rising edge.
- `rst` in, 1 bit: synchronous, active-high reset.
- `start` in, 1 bit: scan request, sampled only in IDLE.
- `sw` in, N_SW bits: switch vector, captured on an accepted start. `sw[0]` is scanned first.
- `busy` out, 1 bit: high in SCAN and DONE.
- `done` out, 1 bit: one-cycle pulse; `count` is valid in the same cycle.
- `count` out, CW bits: number of 1s in the captured `sw`. Holds until the next `done`.
- `all_on` out, 1 bit: registered; equals (`count` == N_SW).

## Operation
- States: IDLE, SCAN, DONE.
- Internal registers:
  - `shreg`, N_SW bits.
  - `acc`, CW bits.
  - `idx`, ceil(log2 N_SW) bits.
- IDLE:
  - `busy`=0, `done`=0.
  - `start`=1: `shreg`<=`sw`, `acc`<=0, `idx`<=0, go to SCAN.
  - `start`=0: remain in IDLE.
- SCAN, each cycle:
  - `acc`<=`acc`+`shreg[0]`; `shreg`<=`shreg`>>1; `idx`<=`idx`+1.
  - When `idx`==N_SW-1: `count`<=final accumulated value, `all_on` updated, go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- `start` in SCAN or DONE is ignored; it is not queued.
- `sw` changes after capture have no effect on the scan in progress.
- Arithmetic: `acc` is unsigned CW bits. The maximum value N_SW fits in CW bits, so overflow is impossible.
- `rst`=1 in any state, including mid-scan: next state IDLE and `shreg`, `acc`, `idx` cleared. `rst` has priority over `start`.

## Timing
- Reset values: `busy`=0, `done`=0, `count`=0, `all_on`=0, state IDLE.
- Cycle numbering: `start` is accepted at the edge ending cycle 0.
- SCAN occupies cycles 1..N_SW. With N_SW=15 that is cycles 1..15, processing `sw[0]`..`sw[14]`.
- `done`=1 and the new `count`/`all_on` appear in cycle N_SW+1 (cycle 16).
- `busy`=1 in cycles 1..16.
- Back in IDLE in cycle 17; earliest next accepted start is in cycle 17.
- `done` pulses are never adjacent: minimum spacing is N_SW+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SWITCH_SCAN_EARLY_EXIT_EN`.
- Defined:
  - In SCAN, if `shreg>>1` (the bits still to be scanned after the current one) is all zero, `count` is loaded and the state goes to DONE at that edge.
  - `sw`=0 gives `done` in cycle 2.
  - Worst case, `sw[N_SW-1]`=1, keeps full latency.
- Undefined: latency is always N_SW+1 cycles from start to `done`, independent of data.
- `count` values are identical in both builds.

## Test plan
- Reset: hold `rst` 2 cycles, release. Required: `busy`=0, `done`=0, `count`=0, `all_on`=0, no `done` without `start`.
- Full count: `sw`=15'h7FFF, `start` pulse in cycle 0. Required: `done` in cycle 16 (baseline), `count`=15, `all_on`=1. Then `sw`=15'h5555 gives `count`=8, `all_on`=0.
- Ignored start: `sw`=15'h000F, `start`; in cycle 5 pulse `start` with `sw`=15'h7FFF. Required: single `done` in cycle 16 with `count`=4, no second scan.
- Reset mid-scan: `start` with `sw`=15'h7FFF; `rst`=1 in cycle 7. Required: `busy`=0 from cycle 8, no `done`, `count`=0. A fresh start with `sw`=15'h0101 gives `count`=2.
- Data ignored after capture: `start` with `sw`=15'h0003, then toggle `sw` every cycle during the scan. Required: `count`=2. Back-to-back starts held high continuously give `done` every 17 cycles.
- Early exit, macro defined:
  - `sw`=15'h0000: `done` in cycle 2, `count`=0.
  - `sw`=15'h0003: `done` in cycle 3, `count`=2.
  - `sw`=15'h4000: `done` in cycle 16, `count`=1.
